// File: rtl/xbar_bridge_pkg.sv
// Shared widths, response opcodes and the response record used by the
// memory-side responder and its response pipeline.
package xbar_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 9;
  localparam int AUX_W  = 8;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  // One response beat as it travels down the latency pipeline.
  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [AUX_W-1:0] aux;
    logic             opc;
    logic [DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/xbar_resp_pipe.sv
// Fixed-latency response delay line: RESP_LAT stages of resp_t, no
// backpressure, strictly in order. Reset empties every stage.
module xbar_resp_pipe
  import xbar_bridge_pkg::*;
#(
  parameter int RESP_LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t din,
  output resp_t dout
);

  resp_t stage [RESP_LAT];

  // Shift the response record one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_LAT; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its predecessor's
      // pre-edge value; blocking ones would collapse the whole line into one stage.
      stage[0] <= din;
      for (int i = 1; i < RESP_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[RESP_LAT-1];

endmodule

// File: rtl/xbar_slave_mem_bank.sv
// Memory-side responder for one bridge slave port: byte-enabled word array
// behind an address window, answering every accepted request after RESP_LAT
// cycles. Widths are expected to match the xbar_bridge_pkg constants, since
// the response record is built from them.
module xbar_slave_mem_bank
  import xbar_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ID_WIDTH   = ID_W,
  parameter int AUX_WIDTH  = AUX_W,
  parameter int MEM_WORDS  = 256,
  parameter int RESP_LAT   = 1,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic [AUX_WIDTH-1:0]  data_aux_i,
  output logic                  data_gnt_o,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [ADDR_WIDTH-1:0] END_ADDR_i,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic                  data_r_opc_o,
  output logic [AUX_WIDTH-1:0]  data_r_aux_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic             accept;
  logic             hit;
  logic [IDX_W-1:0] idx;
  resp_t            resp_in;
  resp_t            resp_out;

  // Grant never looks at the response side, so one request per cycle is sustainable.
  assign data_gnt_o = data_req_i & ~stall_i & ~rst;
  assign accept     = data_gnt_o;

  // An empty or inverted window (END <= START) can never satisfy both bounds.
  assign hit = (data_add_i >= START_ADDR_i) && (data_add_i < END_ADDR_i);

  // Word index relative to the window base; upper bits wrap modulo MEM_WORDS.
  always_comb begin
    idx = IDX_W'((data_add_i - START_ADDR_i) >> 2);
  end

  // Byte-lane write of accepted in-window stores.
  // NOTE: the array is deliberately left out of reset: it is plain storage, and
  // contents written before a reset must survive it.
  always_ff @(posedge clk) begin
    if (accept && hit && !data_wen_i) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Build the response for this cycle's accepted request; idle cycles inject all zeros.
  always_comb begin
    // NOTE: default every field first so no path leaves a value held, which
    // would infer a latch.
    resp_in = '0;
    if (accept) begin
      resp_in.valid = 1'b1;
      resp_in.id    = data_ID_i;
      resp_in.aux   = data_aux_i;
      resp_in.opc   = hit ? OPC_OK : OPC_ERR;
      resp_in.rdata = (hit && data_wen_i) ? mem[idx] : '0;
    end
  end

  xbar_resp_pipe #(
    .RESP_LAT (RESP_LAT)
  ) u_resp_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (resp_in),
    .dout (resp_out)
  );

  assign data_r_valid_o = resp_out.valid;
  assign data_r_rdata_o = resp_out.rdata;
  assign data_r_ID_o    = resp_out.id;
  assign data_r_opc_o   = resp_out.opc;
  assign data_r_aux_o   = resp_out.aux;

endmodule
